// File: rtl/compression_decim_requant_mc.sv
// rtl/compression_decim_requant_mc.sv - multi-channel pick/average decimator with saturating requantization
module compression_decim_requant_mc #(
    parameter int CHANNELS            = 32,
    parameter int DATA_WIDTH          = 26,
    parameter int REQUANTIZED_BITS    = 8,
    parameter int MAX_DEC_LOG2        = 4,
    parameter int SAMPLES_PER_CHANNEL = 3328,
    localparam int DEC_W   = $clog2(MAX_DEC_LOG2 + 1),
    localparam int SHIFT_W = $clog2(DATA_WIDTH)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [CHANNELS*DATA_WIDTH-1:0]       data_i,
    input  logic                                 data_valid_i,
    input  logic                                 frame_start_i,
    input  logic                                 mode_i,
    input  logic [DEC_W-1:0]                     dec_log2_i,
    input  logic [SHIFT_W-1:0]                   shift_i,
    output logic [CHANNELS*REQUANTIZED_BITS-1:0] data_o,
    output logic                                 data_valid_o,
    output logic                                 frame_done_o,
    output logic [CHANNELS-1:0]                  sat_o
);
    localparam int ACC_W = DATA_WIDTH + MAX_DEC_LOG2;
    localparam int PH_W  = (MAX_DEC_LOG2 > 0) ? MAX_DEC_LOG2 : 1;
    localparam int CNT_W = $clog2(SAMPLES_PER_CHANNEL);
    localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'(2 ** (REQUANTIZED_BITS - 1) - 1);
    localparam logic signed [ACC_W-1:0] Q_MIN = ACC_W'(-(2 ** (REQUANTIZED_BITS - 1)));

    typedef enum logic {IDLE, RUN} state_t;

    state_t                              state_q, state_d;
    logic                                mode_q, mode_d;
    logic [SHIFT_W-1:0]                  shift_q, shift_d;
    logic [DEC_W-1:0]                    dec_q, dec_d;
    logic [PH_W-1:0]                     phase_q, phase_d;
    logic [CNT_W-1:0]                    sample_q, sample_d;
    logic signed [ACC_W-1:0]             acc_q [CHANNELS];
    logic signed [ACC_W-1:0]             acc_d [CHANNELS];
    logic [CHANNELS*REQUANTIZED_BITS-1:0] data_q, data_d;
    logic                                valid_q, valid_d;
    logic                                done_q, done_d;
    logic [CHANNELS-1:0]                 sat_q, sat_d;

    logic                                accept, phase0, last_phase;
    logic [PH_W-1:0]                     phase_cur;
    logic [CNT_W-1:0]                    sample_cur;
    logic signed [ACC_W-1:0]             samp_ext [CHANNELS];
    logic signed [ACC_W-1:0]             sum      [CHANNELS];
    logic signed [ACC_W-1:0]             pick_val [CHANNELS];
    logic signed [ACC_W-1:0]             q_val    [CHANNELS];

    always_comb begin
        // The _d config values double as the effective config for a sample arriving with frame_start_i.
        mode_d  = frame_start_i ? mode_i  : mode_q;
        shift_d = frame_start_i ? shift_i : shift_q;
        if (frame_start_i)
            dec_d = (dec_log2_i > DEC_W'(MAX_DEC_LOG2)) ? DEC_W'(MAX_DEC_LOG2) : dec_log2_i;
        else
            dec_d = dec_q;

        phase_cur  = frame_start_i ? '0 : phase_q;
        sample_cur = frame_start_i ? '0 : sample_q;
        accept     = data_valid_i && (frame_start_i || state_q == RUN);
        phase0     = (phase_cur == '0);
        last_phase = (phase_cur == PH_W'((32'd1 << dec_d) - 32'd1));

        state_d  = frame_start_i ? RUN : state_q;
        phase_d  = phase_cur;
        sample_d = sample_cur;
        data_d   = data_q;
        valid_d  = 1'b0;
        done_d   = 1'b0;
        sat_d    = frame_start_i ? '0 : sat_q;

        if (accept) begin
            phase_d  = last_phase ? '0 : phase_cur + PH_W'(1);
            sample_d = sample_cur + CNT_W'(1);
            if (last_phase) begin
                valid_d = 1'b1;
                if (sample_cur == CNT_W'(SAMPLES_PER_CHANNEL - 1)) begin
                    done_d   = 1'b1;
                    sample_d = '0;
                    state_d  = IDLE;
                end
            end
        end

        for (int k = 0; k < CHANNELS; k++) begin
            samp_ext[k] = ACC_W'($signed(data_i[k*DATA_WIDTH +: DATA_WIDTH]));
            sum[k]      = (phase0 ? '0 : acc_q[k]) + samp_ext[k];
            pick_val[k] = phase0 ? samp_ext[k] : acc_q[k];
            q_val[k]    = (mode_d ? (sum[k] >>> dec_d) : pick_val[k]) >>> shift_d;

            if (accept)
                acc_d[k] = mode_d ? sum[k] : pick_val[k];
            else if (frame_start_i)
                acc_d[k] = '0;
            else
                acc_d[k] = acc_q[k];

            if (accept && last_phase) begin
                if (q_val[k] > Q_MAX) begin
                    data_d[k*REQUANTIZED_BITS +: REQUANTIZED_BITS] = Q_MAX[REQUANTIZED_BITS-1:0];
                    sat_d[k] = 1'b1;
                end else if (q_val[k] < Q_MIN) begin
                    data_d[k*REQUANTIZED_BITS +: REQUANTIZED_BITS] = Q_MIN[REQUANTIZED_BITS-1:0];
                    sat_d[k] = 1'b1;
                end else begin
                    data_d[k*REQUANTIZED_BITS +: REQUANTIZED_BITS] = q_val[k][REQUANTIZED_BITS-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            mode_q   <= 1'b0;
            shift_q  <= '0;
            dec_q    <= '0;
            phase_q  <= '0;
            sample_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            sat_q    <= '0;
            for (int k = 0; k < CHANNELS; k++) acc_q[k] <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            shift_q  <= shift_d;
            dec_q    <= dec_d;
            phase_q  <= phase_d;
            sample_q <= sample_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            sat_q    <= sat_d;
            for (int k = 0; k < CHANNELS; k++) acc_q[k] <= acc_d[k];
        end
    end

    assign data_o       = data_q;
    assign data_valid_o = valid_q;
    assign frame_done_o = done_q;
    assign sat_o        = sat_q;
endmodule
